// File: rtl/dafx_gain_ramp_pkg.sv
// Shared types and constants for the gain ramp scheduler.
// Channel indices follow the mixer register-file ordering.
package dafx_gain_ramp_pkg;

    typedef enum logic [0:0] {
        RAMP_IDLE_E,
        RAMP_SCAN_E
    } ramp_state_t;

    localparam int N_MIX_GAINS_C     = 4;
    localparam int GAIN_IDX_OUTPUT_C = 0;
    localparam int GAIN_IDX_CH0_C    = 1;
    localparam int GAIN_IDX_CH1_C    = 2;
    localparam int GAIN_IDX_CH2_C    = 3;

endpackage

// File: rtl/dafx_gain_ramp_scheduler_if.sv
// Register-file side bundle of the gain ramp scheduler.
// master = register file / mixer, slave = scheduler.
interface dafx_gain_ramp_scheduler_if #(
    parameter int GAIN_WIDTH_P = 24,
    parameter int N_CHANNELS_P = 4
);
    logic                             sample_tick;
    logic                             cr_ramp_enable;
    logic [GAIN_WIDTH_P-1:0]          cr_ramp_step;
    logic [N_CHANNELS_P*GAIN_WIDTH_P-1:0] target_gain;
    logic [N_CHANNELS_P*GAIN_WIDTH_P-1:0] gain_out;
    logic                             ramp_busy;
    logic                             ramp_done;
    logic [15:0]                      sr_tick_overruns;

    modport master (
        output sample_tick, cr_ramp_enable, cr_ramp_step, target_gain,
        input  gain_out, ramp_busy, ramp_done, sr_tick_overruns
    );

    modport slave (
        input  sample_tick, cr_ramp_enable, cr_ramp_step, target_gain,
        output gain_out, ramp_busy, ramp_done, sr_tick_overruns
    );
endinterface

// File: rtl/dafx_gain_step.sv
// Saturating single-step unit: moves cur toward tgt by at most step.
// A zero step means jump straight to the target.
module dafx_gain_step #(
    parameter int GAIN_WIDTH_P = 24
) (
    input  logic [GAIN_WIDTH_P-1:0] cur_i,
    input  logic [GAIN_WIDTH_P-1:0] tgt_i,
    input  logic [GAIN_WIDTH_P-1:0] step_i,
    output logic [GAIN_WIDTH_P-1:0] next_o
);
    logic [GAIN_WIDTH_P:0] sum_w;
    logic [GAIN_WIDTH_P:0] dif_w;
    logic [GAIN_WIDTH_P:0] tgt_x_w;

    assign sum_w   = {1'b0, cur_i} + {1'b0, step_i};
    assign dif_w   = {1'b0, cur_i} - {1'b0, step_i};
    assign tgt_x_w = {1'b0, tgt_i};

    // dif_w MSB is the borrow: an underflow always lands on the target
    always_comb begin
        next_o = cur_i;
        if (step_i == '0) begin
            next_o = tgt_i;
        end else if (cur_i < tgt_i) begin
            next_o = (sum_w >= tgt_x_w) ? tgt_i : sum_w[GAIN_WIDTH_P-1:0];
        end else if (cur_i > tgt_i) begin
            next_o = (dif_w[GAIN_WIDTH_P] || dif_w <= tgt_x_w)
                   ? tgt_i : dif_w[GAIN_WIDTH_P-1:0];
        end
    end
endmodule

// File: rtl/dafx_gain_ramp_scheduler.sv
// Per-sample gain ramping with one shared step unit scanned round-robin.
// Optional sticky done interrupt: define DAFX_GAIN_RAMP_IRQ_EN.
module dafx_gain_ramp_scheduler
    import dafx_gain_ramp_pkg::*;
#(
    parameter int                    GAIN_WIDTH_P = 24,
    parameter int                    N_CHANNELS_P = N_MIX_GAINS_C,
    parameter logic [GAIN_WIDTH_P-1:0] GAIN_RESET_P = 1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef DAFX_GAIN_RAMP_IRQ_EN
    output logic irq_ramp_done,
    input  logic cmd_clear_irq,
`endif
    dafx_gain_ramp_scheduler_if.slave bus_if
);
    localparam int IDX_W = (N_CHANNELS_P > 1) ? $clog2(N_CHANNELS_P) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHANNELS_P - 1);

    ramp_state_t state_q;
    logic [IDX_W-1:0] idx_q;
    logic pending_q;
    logic [N_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0] gain_q;
    logic [N_CHANNELS_P-1:0][GAIN_WIDTH_P-1:0] tgt_w;
    logic busy_q, busy_d;
    logic done_q;
    logic [15:0] ovr_q;
    logic [GAIN_WIDTH_P-1:0] step_next_w;

    assign tgt_w  = bus_if.target_gain;
    assign busy_d = (gain_q != tgt_w);

    dafx_gain_step #(.GAIN_WIDTH_P(GAIN_WIDTH_P)) u_step (
        .cur_i  (gain_q[idx_q]),
        .tgt_i  (tgt_w[idx_q]),
        .step_i (bus_if.cr_ramp_step),
        .next_o (step_next_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RAMP_IDLE_E;
            idx_q     <= '0;
            pending_q <= 1'b0;
            ovr_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < N_CHANNELS_P; i++) begin
                gain_q[i] <= GAIN_RESET_P;
            end
        end else begin
            busy_q <= busy_d;
            done_q <= busy_q & ~busy_d & bus_if.cr_ramp_enable;
            if (!bus_if.cr_ramp_enable) begin
                state_q   <= RAMP_IDLE_E;
                idx_q     <= '0;
                pending_q <= 1'b0;
                gain_q    <= tgt_w;
            end else begin
                unique case (state_q)
                    RAMP_IDLE_E: begin
                        if (bus_if.sample_tick || pending_q) begin
                            state_q   <= RAMP_SCAN_E;
                            pending_q <= 1'b0;
                            idx_q     <= '0;
                        end
                    end
                    RAMP_SCAN_E: begin
                        gain_q[idx_q] <= step_next_w;
                        // a tick mid-scan is deferred, not dropped
                        if (bus_if.sample_tick) begin
                            pending_q <= 1'b1;
                            if (ovr_q != 16'hFFFF) begin
                                ovr_q <= ovr_q + 16'd1;
                            end
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q <= RAMP_IDLE_E;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus_if.gain_out         = gain_q;
    assign bus_if.ramp_busy        = busy_q;
    assign bus_if.ramp_done        = done_q;
    assign bus_if.sr_tick_overruns = ovr_q;

`ifdef DAFX_GAIN_RAMP_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else if (done_q) begin
            irq_q <= 1'b1;
        end else if (cmd_clear_irq) begin
            irq_q <= 1'b0;
        end
    end

    assign irq_ramp_done = irq_q;
`endif
endmodule

// File: doc/dafx_gain_ramp_scheduler.md
Name: dafx_gain_ramp_scheduler

Overview:
Sits between the register-file gain outputs (mixer output gain and channel gains 0..2) and the mixer datapath.
It moves each applied gain toward its programmed target by at most one step per audio sample, which removes zipper noise.
A single shared saturating step unit is time-multiplexed round-robin across all channels, and a small FSM sequences it.
Reports busy/done status back to the register file.

Parameters:
GAIN_WIDTH_P, 24, width of every gain word (unsigned)
N_CHANNELS_P, 4, number of ramped gains (index 0 = output gain, 1..3 = channel gains 0..2)
GAIN_RESET_P, 1, reset value of every applied gain (equals register-file gain reset value)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
sample_tick  in  1  one-cycle strobe per audio sample (fs)
cr_ramp_enable  in  1  1 = ramp, 0 = applied gains follow targets directly
cr_ramp_step  in  GAIN_WIDTH_P  maximum change per sample per channel; 0 = jump
target_gain  in  N_CHANNELS_P*GAIN_WIDTH_P  packed targets from register file, channel i at [i*GAIN_WIDTH_P +: GAIN_WIDTH_P]
gain_out  out  N_CHANNELS_P*GAIN_WIDTH_P  applied gains to mixer, same packing
ramp_busy  out  1  high while any applied gain differs from its target
ramp_done  out  1  one-cycle pulse when ramp_busy falls
sr_tick_overruns  out  16  count of sample_tick arriving while a scan is in progress, saturating at 16'hFFFF

Behaviour:
- Reset: every gain_out channel = GAIN_RESET_P, ramp_busy = 0, ramp_done = 0, sr_tick_overruns = 0, FSM in IDLE, pending = 0, channel index = 0.
- FSM states:
  - IDLE -> SCAN when sample_tick = 1 or pending = 1; this clears pending and sets index = 0.
  - SCAN: at the end of each cycle, channel[index] is updated and index increments.
    - After channel N_CHANNELS_P-1 -> IDLE.
    - A scan is exactly N_CHANNELS_P cycles.
- Latency: for sample_tick sampled at edge T, channel i updates at edge T+1+i. Default 4 channels = 4 cycles.
- Step rule (unsigned, GAIN_WIDTH_P+1-bit intermediate):
  - cur < tgt: next = min(cur + step, tgt).
  - cur > tgt: next = max(cur - step, tgt); cur - step computed with borrow, and underflow clamps to tgt.
  - cur == tgt: hold.
  - step = 0: next = tgt.
- target_gain and cr_ramp_step are sampled in the cycle each channel is visited. A target change mid-scan affects only channels not yet visited.
- sample_tick during SCAN: sets pending, which restarts the scan on return to IDLE; sr_tick_overruns += 1, saturating.
  - Tick on the last SCAN cycle also counts as an overrun.
  - Multiple ticks in one scan set pending only once, but each tick counts.
- cr_ramp_enable = 0:
  - Every cycle, all gain_out = target_gain (registered, 1-cycle latency).
  - FSM forced to IDLE, pending cleared, index = 0.
  - Overruns not counted.
- ramp_busy: registered compare of all gain_out vs target_gain, valid 1 cycle after either changes.
- ramp_done: asserted the cycle after ramp_busy goes 1 -> 0; never asserted while cr_ramp_enable = 0.
- gain_out is only ever written from the step unit or the bypass path; there are no glitches between updates.

Optional Feature:
Macro DAFX_GAIN_RAMP_IRQ_EN.
- Defined: adds ports irq_ramp_done (out, 1) and cmd_clear_irq (in, 1).
  - irq_ramp_done sets on ramp_done and stays high until a cmd_clear_irq pulse.
  - Simultaneous set and clear: set wins.
  - Reset value 0.
- Undefined: the ports are absent and no IRQ logic is generated; all other behaviour is identical.

Decomposition:
- Shared package dafx_gain_ramp_pkg holds:
  - typedef enum logic [0:0] {RAMP_IDLE_E, RAMP_SCAN_E} ramp_state_t
  - constant N_MIX_GAINS_C = 4
  - channel index constants (GAIN_IDX_OUTPUT_C, GAIN_IDX_CH0_C..GAIN_IDX_CH2_C)
- Sub-module dafx_gain_step (purely combinational; cur, tgt, step -> next) implements the step rule. It is instantiated once and shared.

Test Plan:
- Reset, then target ch0 = 100, step = 30, enable = 1, ticks every 64 cycles:
  - ch0 goes 1, 31, 61, 91, 100, each at tick edge + 1.
  - ramp_busy goes high, and ramp_done pulses once after reaching 100.
- ch2 = 100 -> target 0, step = 40:
  - Sequence 60, 20, 0; no underflow wrap.
  - Same ramp with step = 0 gives a jump to 0 on the first tick.
- Two ticks 2 cycles apart (inside one 4-cycle scan):
  - sr_tick_overruns = 1.
  - A second scan starts immediately after the first; each channel steps twice.
- Change target ch3 from 50 to 10 during the cycle ch1 is being visited: ch3 uses target 10 in the same scan.
- cr_ramp_enable = 0 mid-scan with targets {5, 6, 7, 8}:
  - The next cycle, gain_out = {5, 6, 7, 8}, FSM is IDLE, and there is no ramp_done pulse.
  - Re-enabling shows no ramp_busy.
- With DAFX_GAIN_RAMP_IRQ_EN: irq_ramp_done sets on ramp_done and clears on cmd_clear_irq; with set and clear in the same cycle it stays 1.
